eca_ribbon: RTL

ECA_RIBBON -- requirements
Module: eca_ribbon

---
 rtl/eca_pkg.sv | 23 ++
 rtl/eca_ribbon_if.sv | 30 +++
 rtl/eca_cell.sv | 12 +
 rtl/eca_ribbon.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular-automaton ribbon.
package eca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] BND_ZERO = 2'd0;
  localparam logic [1:0] BND_ONE  = 2'd1;
  localparam logic [1:0] BND_WRAP = 2'd2;

  // Value seen beyond the ribbon edge; mode 3 falls through to zero.
  function automatic logic edge_bit(input logic [1:0] mode, input logic far_cell);
    case (mode)
      BND_ONE:  return 1'b1;
      BND_WRAP: return far_cell;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/eca_ribbon_if.sv
// Control/status bundle of the ECA ribbon; master drives commands, slave is the ribbon.
interface eca_ribbon_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic [7:0]                   rule_i;
  logic [1:0]                   bound_i;
  logic [WIDTH-1:0]             seed_i;
  logic                         load_i;
  logic                         start_i;
  logic [CNT_W-1:0]             gens_i;
  logic                         stop_i;
  logic [$clog2(WIDTH)-1:0]     rd_idx_i;
  logic                         rd_bit_o;
  logic [WIDTH-1:0]             cells_o;
  logic [31:0]                  gen_cnt_o;
  logic [$clog2(WIDTH+1)-1:0]   alive_o;
  logic                         busy_o;
  logic                         done_o;

  modport master (
    output rule_i, bound_i, seed_i, load_i, start_i, gens_i, stop_i, rd_idx_i,
    input  rd_bit_o, cells_o, gen_cnt_o, alive_o, busy_o, done_o
  );

  modport slave (
    input  rule_i, bound_i, seed_i, load_i, start_i, gens_i, stop_i, rd_idx_i,
    output rd_bit_o, cells_o, gen_cnt_o, alive_o, busy_o, done_o
  );
endinterface

// File: rtl/eca_cell.sv
// One automaton cell: the neighbourhood {m,s,p} selects a bit of the Wolfram rule.
module eca_cell (
  input  logic [7:0] rule,
  input  logic       m,
  input  logic       s,
  input  logic       p,
  output logic       next
);

  assign next = rule[{m, s, p}];

endmodule

// File: rtl/eca_ribbon.sv
// Elementary cellular automaton ribbon: runs a requested number of generations
// with a latched rule and edge mode, and reports population and read-back taps.
module eca_ribbon
  import eca_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  eca_ribbon_if.slave   bus
);

  localparam int AW     = $clog2(WIDTH + 1);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int PADDED = 1 << LEVELS;

  state_t           state, state_next;
  logic [WIDTH-1:0] cells, cells_next;
  logic [31:0]      gen_cnt;
  logic [CNT_W-1:0] remaining;
  logic [7:0]       rule_q;
  logic [1:0]       bound_q;
  logic             rd_bit_q;
  logic [AW-1:0]    alive_q;
  logic [AW-1:0]    pop_sum;
  logic             busy, done;
  logic             left_edge, right_edge;

  assign left_edge  = edge_bit(bound_q, cells[WIDTH-1]);
  assign right_edge = edge_bit(bound_q, cells[0]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic m, p;
    if (i == 0) begin : g_lo
      assign m = left_edge;
    end else begin : g_lo_in
      assign m = cells[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi
      assign p = right_edge;
    end else begin : g_hi_in
      assign p = cells[i+1];
    end
    eca_cell u_cell (.rule(rule_q), .m(m), .s(cells[i]), .p(p), .next(cells_next[i]));
  end

  // Population count: leaves padded to a power of two, then pairwise adder levels.
  logic [AW-1:0] leaf [PADDED];
  for (genvar j = 0; j < PADDED; j++) begin : g_leaf
    if (j < WIDTH) begin : g_real
      assign leaf[j] = AW'(cells[j]);
    end else begin : g_pad
      assign leaf[j] = '0;
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : lvl
    localparam int N = PADDED >> l;
    logic [AW-1:0] sum [N];
    for (genvar k = 0; k < N; k++) begin : node
      if (l == 1) begin : g_first
        assign sum[k] = leaf[2*k] + leaf[2*k+1];
      end else begin : g_upper
        assign sum[k] = lvl[l-1].sum[2*k] + lvl[l-1].sum[2*k+1];
      end
    end
  end

  assign pop_sum = lvl[LEVELS].sum[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A stop request wins over natural completion, so an aborted run never pulses done.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!bus.load_i && bus.start_i)
          state_next = (bus.gens_i == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop_i)                    state_next = ST_IDLE;
        else if (remaining == CNT_W'(1))   state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells     <= '0;
      gen_cnt   <= '0;
      remaining <= '0;
      rule_q    <= '0;
      bound_q   <= '0;
      rd_bit_q  <= 1'b0;
      alive_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load_i) begin
            cells   <= bus.seed_i;
            gen_cnt <= '0;
          end else if (bus.start_i && bus.gens_i != '0) begin
            rule_q    <= bus.rule_i;
            bound_q   <= bus.bound_i;
            remaining <= bus.gens_i;
          end
        end
        ST_RUN: begin
          cells     <= cells_next;
          gen_cnt   <= gen_cnt + 32'd1;
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
      rd_bit_q <= cells[bus.rd_idx_i];
      alive_q  <= pop_sum;
    end
  end

  assign bus.cells_o   = cells;
  assign bus.gen_cnt_o = gen_cnt;
  assign bus.rd_bit_o  = rd_bit_q;
  assign bus.alive_o   = alive_q;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;

endmodule
